// File: rtl/mioc_pattern_seq.sv
// mioc_pattern_seq: applies queued 4-bit stimulus patterns to an external register under test,
// waits a fixed settle time, samples q/qbar and reports a pass/fail result per pattern.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   pat_valid/pat_ready  pattern input handshake (pat_ready = FIFO not full)
//   pat_data, pat_exp    pattern (bit3->in1 .. bit0->in4) and expected q
//   in1..in4             stimulus driven to the register under test
//   q, qbar              register under test outputs
//   res_valid/res_ready  result output handshake
//   res_data             {pattern[3:0], q, qbar, pass}
//   err_count            saturating count of failed patterns
//   busy                 FSM not idle or FIFO non-empty
module mioc_pattern_seq #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pat_valid,
    output logic       pat_ready,
    input  logic [3:0] pat_data,
    input  logic       pat_exp,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       in4,
    input  logic       q,
    input  logic       qbar,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [6:0] res_data,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StReport} state_e;

    // Pattern FIFO; entries are {pattern, expected q}
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [4:0]    rd_entry;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] pat_q, pat_d;
    logic       exp_q, exp_d;
    logic       res_valid_q, res_valid_d;
    logic [6:0] res_data_q, res_data_d;
    logic [7:0] err_q, err_d;
    logic       pass;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = pat_valid && !full;
    assign rd_entry = mem[rd_ptr_q];

    // Storage has no reset; validity is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {pat_data, pat_exp};
        end
    end

    // Pointers wrap modulo DEPTH naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pat_q       <= '0;
            exp_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            exp_q       <= exp_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign pass = (q == exp_q) && (qbar == !q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        exp_d       = exp_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                // Stimulus only ever changes here, so in1..in4 hold while idle
                if (!empty) begin
                    pop     = 1'b1;
                    pat_d   = rd_entry[4:1];
                    exp_d   = rd_entry[0];
                    cnt_d   = 8'(SETTLE_CYCLES - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Loaded with SETTLE_CYCLES-1 so the state lasts SETTLE_CYCLES cycles
                if (cnt_q == '0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSample: begin
                res_data_d  = {pat_q, q, qbar, pass};
                res_valid_d = 1'b1;
                state_d     = StReport;
            end
            StReport: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!res_data_q[0] && (err_q != 8'hff)) begin
                        err_d = err_q + 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pat_ready = !full;
    assign in1       = pat_q[3];
    assign in2       = pat_q[2];
    assign in3       = pat_q[1];
    assign in4       = pat_q[0];
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err_count = err_q;
    assign busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_mioc_pattern_seq.sv
module tb_mioc_pattern_seq;

    localparam int S = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pat_valid, pat_ready, pat_exp;
    logic [3:0] pat_data;
    logic       in1, in2, in3, in4;
    logic       q, qbar;
    logic       res_valid, res_ready;
    logic [6:0] res_data;
    logic [7:0] err_count;
    logic       busy;

    // Second instance with the minimum settle time
    logic       pv1, pr1, pe1, rv1, rr1, bz1;
    logic [3:0] pd1;
    logic       a1, a2, a3, a4;
    logic [6:0] rd1;
    logic [7:0] ec1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [6:0] sb [$];

    mioc_pattern_seq #(.SETTLE_CYCLES(S), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data), .pat_exp(pat_exp),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .q(q), .qbar(qbar),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_count(err_count), .busy(busy)
    );

    mioc_pattern_seq #(.SETTLE_CYCLES(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst),
        .pat_valid(pv1), .pat_ready(pr1), .pat_data(pd1), .pat_exp(pe1),
        .in1(a1), .in2(a2), .in3(a3), .in4(a4),
        .q(q), .qbar(qbar),
        .res_valid(rv1), .res_ready(rr1), .res_data(rd1),
        .err_count(ec1), .busy(bz1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [3:0] p, input logic e, input bit track);
        int t = 0;
        while (!pat_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("push_ready_timeout", 32'(pat_ready), 1);
        pat_valid = 1'b1;
        pat_data  = p;
        pat_exp   = e;
        if (track) sb.push_back({p, q, qbar, (q == e) && (qbar == !q)});
        @(negedge clk);
        pat_valid = 1'b0;
    endtask

    // Waits for a result with res_ready high, compares it, returns after the handshake edge
    task automatic collect(input string tag);
        int t = 0;
        logic [6:0] e;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        e = (sb.size() != 0) ? sb.pop_front() : 7'h7f;
        check({tag, "_valid"}, 32'(res_valid), 1);
        check({tag, "_data"}, 32'(res_data), 32'(e));
        @(negedge clk);
    endtask

    // Single pass with exact latency; assumes idle, empty FIFO, in1..in4 == 0, err_count == 0
    task automatic single_pass(input string tag);
        q = 1'b1; qbar = 1'b0; res_ready = 1'b1;
        pat_valid = 1'b1; pat_data = 4'b1010; pat_exp = 1'b1;
        sb.push_back(7'b1010_10_1);
        @(negedge clk);
        pat_valid = 1'b0;
        check({tag, "_in_before"}, 32'({in1, in2, in3, in4}), 0);
        @(negedge clk);
        check({tag, "_in_applied"}, 32'({in1, in2, in3, in4}), 32'(4'b1010));
        repeat (S) @(negedge clk);
        check({tag, "_valid_early"}, 32'(res_valid), 0);
        @(negedge clk);
        collect(tag);
        check({tag, "_valid_drop"}, 32'(res_valid), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(pat_ready), 1);
        check({tag, "_in"}, 32'({in1, in2, in3, in4}), 0);
        check({tag, "_valid"}, 32'(res_valid), 0);
        check({tag, "_data"}, 32'(res_data), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; pat_valid = 1'b0; pat_data = '0; pat_exp = 1'b0;
        q = 1'b0; qbar = 1'b1; res_ready = 1'b1;
        pv1 = 1'b0; pd1 = '0; pe1 = 1'b0; rr1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Single pass with latency
        single_pass("pass1");

        // Mismatch with q == qbar fault
        q = 1'b1; qbar = 1'b1;
        push(4'b0001, 1'b0, 1'b1);
        collect("fault");
        check("fault_err", 32'(err_count), 1);

        // Backpressure: one in flight plus four queued
        q = 1'b1; qbar = 1'b0; res_ready = 1'b0;
        push(4'b0011, 1'b1, 1'b1);
        push(4'b0100, 1'b0, 1'b1);
        push(4'b0101, 1'b1, 1'b1);
        push(4'b0110, 1'b0, 1'b1);
        push(4'b0111, 1'b1, 1'b1);
        check("bp_full_ready", 32'(pat_ready), 0);
        check("bp_busy", 32'(busy), 1);
        pat_valid = 1'b1; pat_data = 4'b1111; pat_exp = 1'b1;
        repeat (12) @(negedge clk);
        check("bp_res_valid", 32'(res_valid), 1);
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_data", 32'(res_data), 32'(sb[0]));
            check("bp_hold_ready", 32'(pat_ready), 0);
            @(negedge clk);
        end
        pat_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) collect("bp_drain");
        check("bp_err", 32'(err_count), 3);
        check("bp_idle", 32'(busy), 0);
        check("bp_sb_empty", 32'(sb.size()), 0);

        // Saturation of err_count
        q = 1'b1; qbar = 1'b1;
        for (int i = 0; i < 260; i++) begin
            push(4'(i), 1'b1, 1'b1);
            collect("sat");
            if (i == 250) check("sat_254", 32'(err_count), 254);
            if (i == 251) check("sat_255", 32'(err_count), 255);
        end
        check("sat_final", 32'(err_count), 255);

        // Reset while a result waits in REPORT
        q = 1'b1; qbar = 1'b0; res_ready = 1'b0;
        push(4'b1001, 1'b1, 1'b0);
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rpt_reset_pre_valid", 32'(res_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rpt_reset");
        res_ready = 1'b1;

        // Reset during the third settle cycle, with a second pattern queued
        push(4'b1100, 1'b1, 1'b0);
        push(4'b1101, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_settle_in", 32'({in1, in2, in3, in4}), 32'(4'b1100));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("mid_reset");
        repeat (15) @(negedge clk);
        check("mid_no_result", 32'(res_valid), 0);
        check("mid_still_idle", 32'(busy), 0);
        single_pass("pass2");

        // SETTLE_CYCLES = 1 instance
        q = 1'b1; qbar = 1'b0;
        pv1 = 1'b1; pd1 = 4'b1010; pe1 = 1'b1;
        @(negedge clk);
        pv1 = 1'b0;
        check("s1_valid_p0", 32'(rv1), 0);
        @(negedge clk);
        check("s1_in", 32'({a1, a2, a3, a4}), 32'(4'b1010));
        check("s1_valid_p1", 32'(rv1), 0);
        @(negedge clk);
        check("s1_valid_p2", 32'(rv1), 0);
        @(negedge clk);
        check("s1_valid_p3", 32'(rv1), 1);
        check("s1_data", 32'(rd1), 32'(7'b1010_10_1));
        @(negedge clk);
        check("s1_drop", 32'(rv1), 0);
        check("s1_err", 32'(ec1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mioc_pattern_seq.md
MIOC_PATTERN_SEQ -- requirements
Module: mioc_pattern_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter SETTLE_CYCLES SHALL default to 8 and set the DUT settle time in clk cycles; the legal range is 1..255.
REQ-003 Parameter DEPTH SHALL default to 4 and set the pattern FIFO depth; it SHALL be a power of two, minimum 2.
REQ-004 The ports SHALL be, in this order (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pat_valid  in  1  pattern offered
- pat_ready  out  1  pattern FIFO can accept
- pat_data  in  4  pattern; bit3->in1, bit2->in2, bit1->in3, bit0->in4
- pat_exp  in  1  expected q for this pattern
- in1, in2, in3, in4  out  1 each  drive to the register under test
- q, qbar  in  1 each  outputs of the register under test
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  7  {pattern[3:0], q, qbar, pass}
- err_count  out  8  saturating count of failed patterns
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty

Function
REQ-005 The FIFO SHALL store {pat_data, pat_exp} and push on a clk edge where pat_valid && pat_ready.
REQ-006 pat_ready SHALL equal !full; when full, pat_valid SHALL be ignored and no data SHALL be lost or overwritten.
REQ-007 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and REPORT.
REQ-008 IDLE, FIFO non-empty: at the next edge, pop one entry, load in1..in4 from the pattern, latch exp, set cnt=SETTLE_CYCLES-1, and go to SETTLE.
REQ-009 IDLE, FIFO empty: remain in IDLE; in1..in4 SHALL hold the last applied pattern.
REQ-010 SETTLE: cnt SHALL decrement each cycle; on the edge where cnt==0, the FSM SHALL go to SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-011 SAMPLE: at the next edge, register q and qbar into res_data, compute pass=(q==exp)&&(qbar==!q), assert res_valid, and go to REPORT.
REQ-012 Latency: in1..in4 SHALL change 1 edge after the accepting push into an empty FIFO with the FSM in IDLE, and res_valid SHALL rise SETTLE_CYCLES+2 edges after that push (10 at default).
REQ-013 REPORT: res_valid and res_data SHALL hold stable until res_ready; on the handshake edge, res_valid SHALL drop and the FSM SHALL go to IDLE.
REQ-014 On the REPORT handshake edge, if pass==0, err_count SHALL increment, saturating at 255 with no wrap.
REQ-015 FIFO pushes SHALL continue during SETTLE, SAMPLE and REPORT; a push and a pop on the same edge SHALL leave the occupancy unchanged.
REQ-016 in1..in4 SHALL NOT change outside the IDLE->SETTLE transition.
REQ-017 The FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-018 With rst high at an edge, the block SHALL force: FSM=IDLE, FIFO empty, pat_ready=1 on the following cycle, in1..in4=0, res_valid=0, res_data=0, err_count=0, busy=0, cnt=0.
REQ-019 Reset asserted in any state, including mid-SETTLE or during REPORT with res_ready low, SHALL discard the pending pattern and any unconsumed result.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single pass: push 4'b1010, exp=1, with q=1, qbar=0 and res_ready=1 -> in1..in4=1,0,1,0 one edge after push; res_valid rises 10 edges after push; res_data=7'b1010_10_1; err_count=0.
- Mismatch and fault: push 4'b0001, exp=0, with q=1, qbar=1 -> pass=0, err_count=1 after handshake.
- Backpressure: keep res_ready low, push 5 patterns -> pat_ready=0 after the FIFO is full (4 entries plus 1 in flight); res_data stays stable; releasing res_ready drains results in push order.
- Saturation: 260 failing patterns -> err_count stops at 255.
- Reset mid-SETTLE: rst high for 1 edge during the 3rd settle cycle -> all outputs at REQ-018 values; no result emitted; a subsequent push behaves as in the first scenario.
- SETTLE_CYCLES=1: single pattern -> res_valid rises 3 edges after push.
